// File: rtl/cache_access_controller.sv
// Sequencer for the direct-mapped write-through data cache and its fixed-latency line-wide memory.
// Optional read hit/miss statistics are built only when CACHE_STATS_EN is defined.
module cache_access_controller #(
  parameter int MEM_LATENCY = 4,
  parameter int CNT_W       = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        hit,
  output logic        stall,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic        cache_refill,
  output logic        cache_wr,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_READ_MISS = 2'd1,
    S_WRITE_MEM = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;
  logic             w_idle;
  logic             w_start_write;
  logic             w_start_miss;
  logic             w_read_hit;

  assign w_last        = (r_cnt == LAST_CNT);
  assign w_idle        = (r_state == S_IDLE);
  // Stores win over loads when both are requested in the same cycle.
  assign w_start_write = w_idle && MemWrite;
  assign w_start_miss  = w_idle && !MemWrite && MemRead && !hit;
  assign w_read_hit    = w_idle && !MemWrite && MemRead && hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (!w_idle && !w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_write) begin
          w_next = S_WRITE_MEM;
        end else if (w_start_miss) begin
          w_next = S_READ_MISS;
        end
      end
      S_READ_MISS: if (w_last) w_next = S_IDLE;
      S_WRITE_MEM: if (w_last) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Outputs are qualified by rst_n so an asserted reset silences them combinationally.
  always_comb begin
    stall        = 1'b0;
    mem_rd_en    = 1'b0;
    mem_wr_en    = 1'b0;
    cache_refill = 1'b0;
    cache_wr     = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_IDLE: begin
          if (w_start_write) begin
            stall    = 1'b1;
            cache_wr = hit;
          end else if (w_start_miss) begin
            stall = 1'b1;
          end
        end
        S_READ_MISS: begin
          stall        = 1'b1;
          mem_rd_en    = 1'b1;
          cache_refill = w_last;
        end
        S_WRITE_MEM: begin
          stall     = !w_last;
          mem_wr_en = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;
  logic        r_after_refill;

  // The lookup right after a refill is the replay of the missed load, not a new hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count    <= '0;
      r_miss_count   <= '0;
      r_after_refill <= 1'b0;
    end else begin
      if (w_read_hit && !r_after_refill && (r_hit_count != 16'hFFFF)) begin
        r_hit_count <= r_hit_count + 16'd1;
      end
      if (w_start_miss && (r_miss_count != 16'hFFFF)) begin
        r_miss_count <= r_miss_count + 16'd1;
      end
      if (cache_refill) begin
        r_after_refill <= 1'b1;
      end else if (w_idle) begin
        r_after_refill <= 1'b0;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  assign hit_count  = 16'h0;
  assign miss_count = 16'h0;
`endif

endmodule

// File: tb/tb_cache_access_controller.sv
// Directed vector table plus randomized run against a scheduled-output reference model.
module tb_cache_access_controller;

  localparam int L = 4;
`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // Expected output bits: {stall, mem_rd_en, mem_wr_en, cache_refill, cache_wr}
  localparam logic [4:0] Z  = 5'b00000;
  localparam logic [4:0] S  = 5'b10000;
  localparam logic [4:0] RD = 5'b01000;
  localparam logic [4:0] WR = 5'b00100;
  localparam logic [4:0] RF = 5'b00010;
  localparam logic [4:0] CW = 5'b00001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic        hit = 1'b0;
  logic        stall, mem_rd_en, mem_wr_en, cache_refill, cache_wr;
  logic [15:0] hit_count, miss_count;

  int n_vec = 0;
  int n_bad = 0;

  cache_access_controller #(.MEM_LATENCY(L), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite), .hit(hit),
    .stall(stall), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .cache_refill(cache_refill), .cache_wr(cache_wr),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rd;
    logic        wr;
    logic        ht;
    logic [4:0]  exp;
    logic [15:0] eh;
    logic [15:0] em;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst, input logic rd, input logic wr, input logic ht,
                              input logic [4:0] exp, input int h, input int m);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.ht = ht; v.exp = exp;
    v.eh = STATS ? 16'(h) : 16'h0;
    v.em = STATS ? 16'(m) : 16'h0;
    tbl.push_back(v);
  endfunction

  // Drives one cycle of inputs at the falling edge and checks outputs shortly after.
  task automatic apply(input string name, input logic rst, input logic rd, input logic wr,
                       input logic ht, input logic [4:0] exp, input logic [15:0] eh,
                       input logic [15:0] em);
    logic [4:0] got;
    @(negedge clk);
    rst_n = rst; MemRead = rd; MemWrite = wr; hit = ht;
    #1;
    got = {stall, mem_rd_en, mem_wr_en, cache_refill, cache_wr};
    n_vec++;
    if (got !== exp || hit_count !== eh || miss_count !== em) begin
      n_bad++;
      $display("FAIL %s: outs=%b hits=%0d misses=%0d, expected outs=%b hits=%0d misses=%0d",
               name, got, hit_count, miss_count, exp, eh, em);
    end
  endtask

  // Reference model: once a transaction starts, its whole output schedule is queued
  // and replayed regardless of inputs; otherwise the idle decode applies.
  logic [4:0]  sched[$];
  int          mh, mm;
  bit          after_refill;

  task automatic model_step(input logic rst, input logic rd, input logic wr, input logic ht,
                            output logic [4:0] exp);
    if (!rst) begin
      exp = Z;
      sched.delete();
      mh = 0; mm = 0; after_refill = 0;
    end else if (sched.size() > 0) begin
      exp = sched[0];
      if ((sched[0] & RF) != Z) after_refill = 1;
      void'(sched.pop_front());
    end else begin
      exp = Z;
      if (wr) begin
        exp = S | (ht ? CW : Z);
        for (int i = 0; i < L; i++) sched.push_back(i == L - 1 ? WR : (S | WR));
      end else if (rd && ht) begin
        if (!after_refill && mh != 16'hFFFF) mh++;
      end else if (rd) begin
        exp = S;
        if (mm != 16'hFFFF) mm++;
        for (int i = 0; i < L; i++) sched.push_back(i == L - 1 ? (S | RD | RF) : (S | RD));
      end
      after_refill = 0;
    end
  endtask

  initial begin
    logic [4:0]  e;
    logic [15:0] eh, em;
    logic        r, d, w, h;

    // Reset holds everything low even with all requests asserted.
    add(0, 1, 1, 0, Z, 0, 0);
    for (int i = 0; i < 10; i++) add(1, 0, 0, 0, Z, 0, 0);
    // Read hit, then read miss with refill and the replayed lookup.
    add(1, 1, 0, 1, Z, 0, 0);
    add(1, 1, 0, 0, S, 1, 0);
    add(1, 1, 0, 0, S | RD, 1, 1);
    add(1, 1, 0, 0, S | RD, 1, 1);
    add(1, 1, 0, 0, S | RD, 1, 1);
    add(1, 1, 0, 0, S | RD | RF, 1, 1);
    add(1, 1, 0, 1, Z, 1, 1);
    add(1, 1, 0, 1, Z, 1, 1);
    add(1, 0, 0, 0, Z, 2, 1);
    // Write hit: cache_wr in the idle cycle, then four memory-write cycles.
    add(1, 0, 1, 1, S | CW, 2, 1);
    add(1, 0, 1, 1, S | WR, 2, 1);
    add(1, 0, 1, 1, S | WR, 2, 1);
    add(1, 0, 1, 1, S | WR, 2, 1);
    add(1, 0, 1, 1, WR, 2, 1);
    add(1, 0, 0, 0, Z, 2, 1);
    // Load and store together on a miss: the store path wins.
    add(1, 1, 1, 0, S, 2, 1);
    add(1, 1, 1, 0, S | WR, 2, 1);
    add(1, 1, 1, 0, S | WR, 2, 1);
    add(1, 1, 1, 0, S | WR, 2, 1);
    add(1, 1, 1, 0, WR, 2, 1);
    add(1, 0, 0, 0, Z, 2, 1);
    // Reset while the read miss is at its third memory cycle.
    add(1, 1, 0, 0, S, 2, 1);
    add(1, 1, 0, 0, S | RD, 2, 2);
    add(1, 1, 0, 0, S | RD, 2, 2);
    add(0, 1, 0, 0, Z, 0, 0);
    add(0, 1, 0, 0, Z, 0, 0);
    add(1, 0, 0, 0, Z, 0, 0);
    add(1, 1, 0, 0, S, 0, 0);
    add(1, 1, 0, 0, S | RD, 0, 1);
    add(1, 1, 0, 0, S | RD, 0, 1);
    add(1, 1, 0, 0, S | RD, 0, 1);
    add(1, 1, 0, 0, S | RD | RF, 0, 1);
    add(1, 0, 0, 0, Z, 0, 1);

    foreach (tbl[i]) begin
      apply($sformatf("vec%0d", i), tbl[i].rst, tbl[i].rd, tbl[i].wr, tbl[i].ht,
            tbl[i].exp, tbl[i].eh, tbl[i].em);
    end

    // Randomized run; the reset vector clears both DUT and model.
    model_step(0, 0, 0, 0, e);
    apply("rand_reset", 0, 0, 0, 0, Z, 16'h0, 16'h0);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) != 0);
      d = ($urandom_range(0, 1) == 1);
      w = ($urandom_range(0, 3) == 0);
      h = ($urandom_range(0, 1) == 1);
      // Counts visible this cycle are those before the step updates them.
      eh = STATS ? 16'(mh) : 16'h0;
      em = STATS ? 16'(mm) : 16'h0;
      if (!r) begin
        eh = 16'h0;
        em = 16'h0;
      end
      model_step(r, d, w, h, e);
      apply($sformatf("rand%0d", i), r, d, w, h, e, eh, em);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
